adc_burst_ctrl: RTL
===================

Name: adc_burst_ctrl

Overview:
- Parametrised serial ADC front-end controller; successor to the single-channel 12-bit ADC controller.
- Drives sync/sclk to an SPI-style ADC and deserialises sdo into DATA_W-bit samples.
- Supports single-shot and n-sample burst modes, abort, and a per-sample valid strobe.
- Sits between the ADC pins and the sample buffer/host logic, all in the clk_in domain.

Parameters:
- DATA_W, 12, sample width; the last DATA_W bits of each frame.
- FRAME_BITS, 16, sclk cycles per conversion; requires FRAME_BITS >= DATA_W.
- CLK_DIV, 4, clk_in cycles per sclk half-period; requires CLK_DIV >= 1.
- QUIET_CYC, 8, clk_in cycles sync is held high between conversions; requires QUIET_CYC >= 1.
- N_W, 12, width of the burst count n.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = single conversion, 1 = burst of n conversions; sampled together with ctrl.
- n  in  N_W  burst length; sampled together with ctrl.
- abort  in  1  terminate the current operation.
- sdo  in  1  ADC serial data, MSB first.
- sync  out  1  ADC chip select, active low.
- sclk  out  1  ADC serial clock, idles high.
- data  out  DATA_W  last completed sample; holds until the next valid.
- valid  out  1  one-cycle strobe when data updates.
- ready  out  1  high in IDLE only.
- sample_cnt  out  N_W  samples completed in the current or last operation.

Behaviour:
- Reset values: sync=1, sclk=1, data=0, valid=0, ready=1, sample_cnt=0; FSM=IDLE. Reset mid-frame aborts immediately, with no valid.
- FSM states: IDLE, CONV, QUIET.
- IDLE: ready=1. On ctrl=1, latch mode and n, clear sample_cnt, and enter CONV on the next cycle with sync=0 and ready=0. Start latency is 1 clk_in cycle.
- Burst with n=0 is treated as n=1. A single conversion (mode=0) ignores n.
- CONV timing:
  - A divider counts CLK_DIV cycles per half-period.
  - sclk toggles 1->0, then 0->1, for each bit, FRAME_BITS times.
  - sdo is captured on the clk_in edge where sclk goes 0->1.
  - sync is low for exactly FRAME_BITS*2*CLK_DIV cycles (default 128).
- Frame completion, on the cycle after the last capture:
  - sync=1, sclk=1.
  - data = last DATA_W captured bits, MSB first; the leading FRAME_BITS-DATA_W bits are discarded.
  - valid=1 for 1 cycle; sample_cnt increments.
  - The FSM enters QUIET.
- QUIET: hold sync=1 for QUIET_CYC cycles. Then:
  - if burst and sample_cnt < latched n, enter CONV;
  - otherwise enter IDLE, with ready=1 in the first IDLE cycle.
- ctrl, mode and n changes while ready=0 are ignored.
- abort=1 in CONV or QUIET:
  - Next cycle: sync=1, sclk=1, FSM=IDLE, ready=1.
  - The partial frame is discarded, with no valid. data and sample_cnt hold.
- abort in IDLE has no effect. abort and ctrl together in IDLE: abort wins and no start occurs.
- sample_cnt saturates at 2^N_W-1 (unreachable for legal n).
- Burst sample period: FRAME_BITS*2*CLK_DIV + 1 + QUIET_CYC cycles.

Optional Feature:
- Macro: ADC_BURST_ACCUM_EN.
- When defined, add the following outputs, both resetting to 0:
  - acc_sum, width DATA_W+N_W: running sum of all samples in the current burst. Cleared on start; updated in the same cycle as valid.
  - acc_done: one-cycle pulse on the cycle the FSM returns to IDLE after a completed burst, with acc_sum final. No pulse on abort.
- When not defined, these ports and the adder are absent, and the remaining behaviour is identical.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-frame; separately, hold rst for 5 cycles.
  - Response: sync=1, sclk=1, ready=1, valid=0, data=0 during reset; no valid afterwards.
- Single conversion:
  - Stimulus: the ADC model drives frame 0x0A5C (bit changes on the sclk falling edge); pulse ctrl with mode=0.
  - Response: sync low 128 cycles; 16 sclk rising edges; valid once; data=0xA5C; sample_cnt=1; ready high 8+1 cycles after sync rises.
- Burst:
  - Stimulus: mode=1, n=3, ADC model drives 0x0001, 0x0FFF, 0x0800.
  - Response: 3 valid pulses 137 cycles apart; data sequence 0x001, 0xFFF, 0x800; sample_cnt=3.
  - With ADC_BURST_ACCUM_EN: acc_sum=0x1800 and acc_done pulses once.
- n=0 burst:
  - Stimulus: mode=1, n=0.
  - Response: exactly one conversion; sample_cnt=1.
- Abort:
  - Stimulus: burst n=5; assert abort 40 cycles into the 2nd frame.
  - Response: next cycle sync=1, sclk=1, ready=1; only 1 valid total; sample_cnt=1; data unchanged.
  - With ADC_BURST_ACCUM_EN: no acc_done.
- Busy-ignore and parameter sweep:
  - Stimulus: pulse ctrl repeatedly while busy; rerun the single-conversion test with CLK_DIV=1, FRAME_BITS=12, DATA_W=12.
  - Response: extra ctrl pulses cause no extra frames; sync low for 24 cycles; data matches the driven frame.

Source files
------------

// File: rtl/adc_burst_ctrl.sv
// Serial ADC front-end: drives sync/sclk, deserialises sdo, single-shot or n-sample bursts.
// Optional running accumulator enabled by defining ADC_BURST_ACCUM_EN.
module adc_burst_ctrl #(
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 8,
  parameter int N_W        = 12
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              ctrl,
  input  logic              mode,
  input  logic [N_W-1:0]    n,
  input  logic              abort,
  input  logic              sdo,
  output logic              sync,
  output logic              sclk,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              ready,
  output logic [N_W-1:0]    sample_cnt
`ifdef ADC_BURST_ACCUM_EN
  ,
  output logic [DATA_W+N_W-1:0] acc_sum,
  output logic                  acc_done
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int QC_W  = $clog2(QUIET_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [QC_W-1:0]  QUIET_LAST = QC_W'(QUIET_CYC);
  localparam logic [N_W-1:0]   CNT_MAX    = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] QUIET = 2'd2;

  logic [1:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [QC_W-1:0]   quiet_cnt;
  logic [N_W-1:0]    burst_n;
  logic [DATA_W-2:0] shift;
  logic [DATA_W-1:0] sample;
  logic [N_W-1:0]    start_n;

  assign ready   = (state == IDLE);
  // Only the newest DATA_W-1 bits are kept; leading frame bits fall off the top.
  assign sample  = {shift, sdo};
  assign start_n = (mode && (n != '0)) ? n : N_W'(1);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= 1'b1;
      sclk       <= 1'b1;
      data       <= '0;
      valid      <= 1'b0;
      sample_cnt <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      quiet_cnt  <= '0;
      burst_n    <= '0;
      shift      <= '0;
`ifdef ADC_BURST_ACCUM_EN
      acc_sum    <= '0;
      acc_done   <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef ADC_BURST_ACCUM_EN
      acc_done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ctrl && !abort) begin
            state      <= CONV;
            sync       <= 1'b0;
            sclk       <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            burst_n    <= start_n;
            sample_cnt <= '0;
`ifdef ADC_BURST_ACCUM_EN
            acc_sum    <= '0;
`endif
          end
        end

        CONV: begin
          if (abort) begin
            state <= IDLE;
            sync  <= 1'b1;
            sclk  <= 1'b1;
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bit_cnt != BIT_LAST) begin
              sclk    <= 1'b1;
              shift   <= sample[DATA_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              // Last rising edge: publish the sample and release the ADC.
              sclk      <= 1'b1;
              sync      <= 1'b1;
              data      <= sample;
              valid     <= 1'b1;
              state     <= QUIET;
              quiet_cnt <= '0;
              if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
`ifdef ADC_BURST_ACCUM_EN
              acc_sum   <= acc_sum + (DATA_W+N_W)'(sample);
`endif
            end
          end
        end

        QUIET: begin
          if (abort) begin
            state <= IDLE;
          end else if (quiet_cnt != QUIET_LAST) begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end else if (sample_cnt < burst_n) begin
            state   <= CONV;
            sync    <= 1'b0;
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
`ifdef ADC_BURST_ACCUM_EN
            acc_done <= 1'b1;
`endif
          end
        end

        default: begin
          state <= IDLE;
          sync  <= 1'b1;
          sclk  <= 1'b1;
        end
      endcase
    end
  end

endmodule
